div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- Execute-stage initiator for the iterative divider.
- Accepts one DIV/DIVU/REM/REMU from ex and drives the divider's start/op/operand/waddr inputs.
- Holds start asserted for the whole operation and stalls the pipeline until the result returns.
- Produces a one-cycle registered writeback, and aborts cleanly on pipeline flush by dropping start.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, register write-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  divide instruction present in ex
- req_ready_o  out  1  controller can accept a request this cycle
- req_op_i  in  3  funct3: DIV=100, DIVU=101, REM=110, REMU=111
- req_dividend_i  in  DATA_W  rs1 value
- req_divisor_i  in  DATA_W  rs2 value
- req_waddr_i  in  ADDR_W  rd
- flush_i  in  1  pipeline flush; kills the in-flight divide
- stall_o  out  1  hold upstream pipeline
- div_start_o  out  1  divider start; held high for the whole operation
- div_op_o  out  3  latched op
- div_dividend_o  out  DATA_W  latched dividend
- div_divisor_o  out  DATA_W  latched divisor
- div_waddr_o  out  ADDR_W  latched rd
- div_result_i  in  DATA_W  divider result
- div_ready_i  in  1  divider result-valid pulse (one cycle)
- div_busy_i  in  1  divider busy
- wb_valid_o  out  1  writeback strobe (one cycle)
- wb_data_o  out  DATA_W  writeback data
- wb_waddr_o  out  ADDR_W  writeback rd

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All registered outputs clear to 0: start, op, operands, waddr, wb_valid, wb_data, wb_waddr.
  - req_ready_o=1 and stall_o=0 when the reset is released.
- States: IDLE, BUSY.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & ~flush_i at edge T: latch op/operands/waddr and enter BUSY.
  - start_q=1 from T+1.
  - stall_o=req_valid_i & ~flush_i (combinational).
- BUSY:
  - req_ready_o=0.
  - div_start_o = start_q & ~div_ready_i & ~flush_i (combinational mask). This guarantees start is low in the ready cycle, so the divider does not relaunch from its IDLE.
  - stall_o = ~div_ready_i.
- Completion:
  - div_ready_i=1 & flush_i=0 in cycle R: wb_data_o<=div_result_i, wb_waddr_o<=latched rd, wb_valid_o=1 in R+1 only; state→IDLE, start_q cleared.
  - div_waddr_i is not used; writeback rd always comes from the latch.
- Flush:
  - flush_i in BUSY: start masked low that cycle, start_q cleared, state→IDLE, no writeback.
  - flush_i and div_ready_i in the same cycle: flush wins, wb_valid_o stays 0.
  - flush_i in IDLE: the request is not accepted.
- Back-to-back:
  - Next request may be accepted in R+1; start rises R+2.
  - The divider is guaranteed idle in R+1 because start was low in R.
- Divide-by-zero and signed handling are done entirely by the divider. The controller forwards op unchanged and does no result correction.
- div_busy_i: ignored for control; exposed for assertion only.
  - Bench checks div_busy_i==0 whenever state==IDLE and one cycle has passed since a flush.
- wb_valid_o deasserts the cycle after it pulses. wb_data_o/wb_waddr_o hold until the next writeback.

Optional Feature:
- DIV_RESULT_CACHE_EN
  - Defined:
    - One-entry cache {valid, op, dividend, divisor, result}, written at each completed, non-flushed divide.
    - IDLE request matching all four fields: no divider start; wb_valid_o at T+1 with the cached result; stall_o=0; state stays IDLE.
    - Cache valid cleared on reset only.
  - Undefined: no cache storage; every request takes the divider path.

Test Plan:
- DIVU 100/7, rd=5, accepted T:
  - div_start_o high T+1..R-1 and low in R.
  - stall_o high T..R-1.
  - wb_valid_o=1 at R+1 with data 14, waddr 5, exactly one cycle.
- DIV 0xFFFFFFF9/2 → wb_data 0xFFFFFFFD; REM 0xFFFFFFF9/2 → 0xFFFFFFFF; issued back-to-back.
  - Second start rises exactly 2 cycles after the first R.
  - No spurious second divider launch.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - Short divider path; single wb each.
- flush_i pulsed 10 cycles into DIVU 1000/3:
  - div_start_o low that cycle and stays low; no wb_valid_o.
  - Next DIVU 9/3 gives wb_data 3.
- div_ready_i coincident with flush_i → no wb_valid_o.
  - rst asserted mid-BUSY → start/stall drop immediately (async); state IDLE; req_ready_o=1 after release.
- DIV_RESULT_CACHE_EN defined:
  - Repeat DIVU 100/7 → wb_valid_o at T+1 with data 14; div_start_o never asserts.
  - DIV 100/7 (op differs) → normal divider path.
  - Without the macro, the repeat takes the full divider latency.

Source files
------------

// File: rtl/div_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_if
// Purpose  : Bundle of request, divider and writeback signals that connect the
//            execute-stage divide initiator to its neighbours.
//            slave  = the div_issue_ctrl side, master = the surrounding logic.
// Revision : 1.0 - initial release
// ============================================================================
interface div_issue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // request from ex
  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        req_op_i;
  logic [DATA_W-1:0] req_dividend_i;
  logic [DATA_W-1:0] req_divisor_i;
  logic [ADDR_W-1:0] req_waddr_i;
  logic              flush_i;
  logic              stall_o;
  // divider launch / result
  logic              div_start_o;
  logic [2:0]        div_op_o;
  logic [DATA_W-1:0] div_dividend_o;
  logic [DATA_W-1:0] div_divisor_o;
  logic [ADDR_W-1:0] div_waddr_o;
  logic [DATA_W-1:0] div_result_i;
  logic              div_ready_i;
  logic              div_busy_i;
  // writeback
  logic              wb_valid_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [ADDR_W-1:0] wb_waddr_o;

  modport slave (
    input  req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_waddr_i,
    input  flush_i, div_result_i, div_ready_i, div_busy_i,
    output req_ready_o, stall_o, div_start_o, div_op_o, div_dividend_o,
    output div_divisor_o, div_waddr_o, wb_valid_o, wb_data_o, wb_waddr_o
  );

  modport master (
    output req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_waddr_i,
    output flush_i, div_result_i, div_ready_i, div_busy_i,
    input  req_ready_o, stall_o, div_start_o, div_op_o, div_dividend_o,
    input  div_divisor_o, div_waddr_o, wb_valid_o, wb_data_o, wb_waddr_o
  );
endinterface
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : Execute-stage initiator for the iterative divider. Latches one
//            DIV/DIVU/REM/REMU, holds divider start for the whole operation,
//            stalls ex until the result returns, then emits a one-cycle
//            registered writeback. A flush drops start and abandons the op.
//            Optional build macro DIV_RESULT_CACHE_EN adds a one-entry result
//            cache that answers an exact repeat without using the divider.
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  div_issue_if.slave    bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] wb_waddr_q, wb_waddr_d;

  logic              accept;
  logic              cache_hit;
  logic              unused_busy;

  // divider busy only matters to external checking
  assign unused_busy = bus.div_busy_i;

  assign accept = bus.req_valid_i & ~bus.flush_i;

`ifdef DIV_RESULT_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [2:0]        cache_op_q, cache_op_d;
  logic [DATA_W-1:0] cache_dividend_q, cache_dividend_d;
  logic [DATA_W-1:0] cache_divisor_q, cache_divisor_d;
  logic [DATA_W-1:0] cache_result_q, cache_result_d;

  // exact match on op and both operands reuses the last completed result
  assign cache_hit = cache_valid_q
                   & (cache_op_q       == bus.req_op_i)
                   & (cache_dividend_q == bus.req_dividend_i)
                   & (cache_divisor_q  == bus.req_divisor_i);
`else
  assign cache_hit = 1'b0;
`endif

  // next-state and datapath selection
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    waddr_d    = waddr_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_waddr_d = wb_waddr_q;
`ifdef DIV_RESULT_CACHE_EN
    cache_valid_d    = cache_valid_q;
    cache_op_d       = cache_op_q;
    cache_dividend_d = cache_dividend_q;
    cache_divisor_d  = cache_divisor_q;
    cache_result_d   = cache_result_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cache_hit) begin
            wb_valid_d = 1'b1;
`ifdef DIV_RESULT_CACHE_EN
            wb_data_d  = cache_result_q;
`endif
            wb_waddr_d = bus.req_waddr_i;
          end else begin
            op_d       = bus.req_op_i;
            dividend_d = bus.req_dividend_i;
            divisor_d  = bus.req_divisor_i;
            waddr_d    = bus.req_waddr_i;
            start_d    = 1'b1;
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        // flush takes priority over a coincident result
        if (bus.flush_i) begin
          start_d = 1'b0;
          state_d = IDLE;
        end else if (bus.div_ready_i) begin
          start_d    = 1'b0;
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_data_d  = bus.div_result_i;
          wb_waddr_d = waddr_q;
`ifdef DIV_RESULT_CACHE_EN
          cache_valid_d    = 1'b1;
          cache_op_d       = op_q;
          cache_dividend_d = dividend_q;
          cache_divisor_d  = divisor_q;
          cache_result_d   = bus.div_result_i;
`endif
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      waddr_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_waddr_q <= '0;
`ifdef DIV_RESULT_CACHE_EN
      cache_valid_q    <= 1'b0;
      cache_op_q       <= '0;
      cache_dividend_q <= '0;
      cache_divisor_q  <= '0;
      cache_result_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      waddr_q    <= waddr_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_waddr_q <= wb_waddr_d;
`ifdef DIV_RESULT_CACHE_EN
      cache_valid_q    <= cache_valid_d;
      cache_op_q       <= cache_op_d;
      cache_dividend_q <= cache_dividend_d;
      cache_divisor_q  <= cache_divisor_d;
      cache_result_q   <= cache_result_d;
`endif
    end
  end

  // start is masked in the result cycle so the divider never relaunches
  // from its idle state, and in a flush cycle so the op aborts at once
  assign bus.div_start_o    = start_q & ~bus.div_ready_i & ~bus.flush_i;
  assign bus.req_ready_o    = (state_q == IDLE);
  assign bus.stall_o        = (state_q == IDLE) ? (accept & ~cache_hit)
                                                : ~bus.div_ready_i;
  assign bus.div_op_o       = op_q;
  assign bus.div_dividend_o = dividend_q;
  assign bus.div_divisor_o  = divisor_q;
  assign bus.div_waddr_o    = waddr_q;
  assign bus.wb_valid_o     = wb_valid_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.wb_waddr_o     = wb_waddr_q;

endmodule
`default_nettype wire
